crypto1_key_serializer: RTL and testbench
=========================================

// Module: crypto1_key_serializer
// PURPOSE
// - Core-side transmitter for the found-key bus of the Crypto1 attack top level.
// - Buffers candidate 48-bit keys from a core's verify stage in a small FIFO.
// - Raises KEY_VALID and shifts the head key out MSB-first on KEY_DATA, one bit per falling edge of KEY_CLK.
// - KEY_CLK is driven by the attack top level.
// - Reports DONE once the search has finished and every buffered key has been sent.
// PARAMETERS
// - KEY_W  48  key width in bits
// - DEPTH  4   FIFO depth in keys; power of two, >= 2
// PORTS
// - CLK           in   1      system clock; all logic on posedge
// - RESETn        in   1      synchronous reset, active low
// - KEY_IN        in   KEY_W  candidate key from the verify stage
// - KEY_IN_VALID  in   1      one-cycle push strobe for KEY_IN
// - SEARCH_DONE   in   1      core has exhausted its search space (level)
// - KEY_CLK       in   1      bit clock from the top level; sampled as data on CLK
// - KEY_DATA      out  1      current bit of the head key
// - KEY_VALID     out  1      FIFO not empty
// - OVERFLOW      out  1      sticky: a push was dropped
// - COUNT         out  $clog2(DEPTH)+1  keys held in the FIFO
// - DONE          out  1      SEARCH_DONE, FIFO empty and no transfer in progress
// BEHAVIOUR
// - Clock and reset: one clock, CLK. Reset is synchronous, active-low, on RESETn.
// - Reset values:
//   - KEY_DATA=0, KEY_VALID=0, OVERFLOW=0, COUNT=0, DONE=0.
//   - Pointers, bit index and the registered KEY_CLK copy (kclk_q) are cleared.
// - Reset mid-transfer: the partially sent key is discarded; no bus state is retained.
// - Edge detect: kclk_q <= KEY_CLK. fall = kclk_q & ~KEY_CLK.
// - Rising edges are ignored. KEY_CLK is not used as a clock.
// - States:
//   - IDLE (FIFO empty): KEY_DATA=0.
//   - SEND: KEY_DATA = head[KEY_W-1-bidx], registered.
//   - IDLE->SEND on the first accepted push.
//   - SEND->IDLE after the last bit is consumed with no keys left.
// - Shift: each fall in SEND does bidx++. KEY_DATA shows the new bit on the cycle after fall is detected.
// - End of word: the fall that consumes the final bit (bidx = LAST) performs these steps in that cycle:
//   - pop the head and set bidx=0;
//   - if keys remain, KEY_DATA = MSB of the next head on the following cycle and SEND continues, with no idle gap;
//   - otherwise KEY_VALID=0 on the following cycle.
// - Fall while empty: ignored, no underflow.
// - Push rules:
//   - Accepted when COUNT<DEPTH.
//   - When full, the push is accepted only if a pop occurs in the same cycle; COUNT is then unchanged.
//   - Otherwise the key is dropped, OVERFLOW=1 (cleared only by reset) and COUNT saturates at DEPTH.
// - Pointers wrap modulo DEPTH.
// - COUNT updates the cycle after the push or pop.
// - DONE is registered: DONE <= SEARCH_DONE & (COUNT==0) & ~push. It deasserts if SEARCH_DONE drops.
// CONFIGURATION
// - Macro: CRYPTO1_KEY_PARITY_EN.
// - Defined: each word carries KEY_W+1 bits; after the key LSB, bit KEY_W = odd parity = ~^key. LAST=KEY_W.
// - Undefined: KEY_W bits per word, no parity bit. LAST=KEY_W-1.
// TESTING
// - Serialize one key:
//   - Stimulus: reset, push 0xEE3DE5499562, then toggle KEY_CLK every cycle for 48 falls.
//   - Response: bits sampled before each fall reconstruct 0xEE3DE5499562. KEY_VALID drops 1 cycle after the 48th fall.
// - Back-to-back keys:
//   - Stimulus: push 0x27568D75631F then 0x5A7BE10A7259.
//   - Response: 96 falls recover both keys in order with no gap; COUNT goes 2->1->0.
// - Overflow:
//   - Stimulus: push DEPTH+1 keys with no KEY_CLK activity.
//   - Response: COUNT=4, OVERFLOW=1, and the first 4 keys are sent intact.
// - Push and pop when full:
//   - Stimulus: FIFO full, push in the cycle of the final-bit fall.
//   - Response: key accepted, COUNT stays 4, OVERFLOW=0.
// - Done and reset:
//   - Stimulus: SEARCH_DONE=1 with 1 key queued.
//   - Response: DONE=0 until the last fall, then DONE=1.
//   - Stimulus: RESETn=0 after 20 falls.
//   - Response: all outputs are at their reset values on the next cycle.
// - Parity build (CRYPTO1_KEY_PARITY_EN):
//   - Stimulus: push 0x000000000001.
//   - Response: 49 falls; bit 49 = 0, and KEY_VALID holds through the 48th fall.

Source files
------------

// File: rtl/crypto1_key_serializer.sv
// Crypto1 found-key bus transmitter: FIFO of candidate keys, shifted MSB-first on KEY_CLK falls.
// Define CRYPTO1_KEY_PARITY_EN to append an odd-parity bit after each key LSB.
module crypto1_key_serializer #(
  parameter int KEY_W = 48,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RESETn,
  input  logic [KEY_W-1:0]         KEY_IN,
  input  logic                     KEY_IN_VALID,
  input  logic                     SEARCH_DONE,
  input  logic                     KEY_CLK,
  output logic                     KEY_DATA,
  output logic                     KEY_VALID,
  output logic                     OVERFLOW,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     DONE
);

`ifdef CRYPTO1_KEY_PARITY_EN
  localparam int NB = KEY_W + 1;
`else
  localparam int NB = KEY_W;
`endif
  localparam int LAST = NB - 1;
  localparam int BW   = $clog2(NB);
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;

  typedef enum logic {IDLE, SEND} state_t;

  function automatic logic [NB-1:0] frame(input logic [KEY_W-1:0] k);
`ifdef CRYPTO1_KEY_PARITY_EN
    return {k, ~^k};
`else
    return k;
`endif
  endfunction

  state_t            state_q;
  logic [KEY_W-1:0]  mem [DEPTH];
  logic [PW-1:0]     rd_q, wr_q, rd_n;
  logic [BW-1:0]     bidx_q, bidx_n;
  logic              kclk_q;
  logic              fall, busy, last, pop, push, drop;
  logic [CW-1:0]     count_n;
  logic [KEY_W-1:0]  head_n;
  logic [NB-1:0]     word_n;
  logic              data_n;

  always_comb begin
    fall    = kclk_q & ~KEY_CLK;
    busy    = (state_q == SEND);
    last    = (bidx_q == BW'(LAST));
    pop     = fall & busy & last;
    push    = KEY_IN_VALID & ((COUNT != CW'(DEPTH)) | pop);
    drop    = KEY_IN_VALID & ~push;
    count_n = COUNT + CW'(push) - CW'(pop);
    rd_n    = rd_q + PW'(pop);
    bidx_n  = bidx_q;
    if (fall & busy)
      bidx_n = last ? '0 : bidx_q + BW'(1);
    // a key pushed into an otherwise empty FIFO becomes the head directly
    head_n  = ((COUNT - CW'(pop)) == '0) ? KEY_IN : mem[rd_n];
    word_n  = frame(head_n);
    data_n  = (count_n != '0) & word_n[BW'(LAST) - bidx_n];
  end

  always_ff @(posedge CLK) begin
    if (RESETn && push)
      mem[wr_q] <= KEY_IN;
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_q   <= IDLE;
      rd_q      <= '0;
      wr_q      <= '0;
      bidx_q    <= '0;
      kclk_q    <= 1'b0;
      COUNT     <= '0;
      KEY_DATA  <= 1'b0;
      KEY_VALID <= 1'b0;
      OVERFLOW  <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      kclk_q    <= KEY_CLK;
      rd_q      <= rd_n;
      wr_q      <= wr_q + PW'(push);
      bidx_q    <= bidx_n;
      COUNT     <= count_n;
      KEY_DATA  <= data_n;
      KEY_VALID <= (count_n != '0);
      state_q   <= (count_n != '0) ? SEND : IDLE;
      if (drop)
        OVERFLOW <= 1'b1;
      DONE      <= SEARCH_DONE & (COUNT == '0) & ~push;
    end
  end

endmodule

// File: tb/tb_crypto1_key_serializer.sv
// Self-checking bench for crypto1_key_serializer: vector table plus
// scoreboarded multi-key, overflow, done and reset sequences.
module tb_crypto1_key_serializer;
  localparam int KW    = 48;
  localparam int DEPTH = 4;
`ifdef CRYPTO1_KEY_PARITY_EN
  localparam int NB = KW + 1;
`else
  localparam int NB = KW;
`endif

  logic          CLK = 1'b0;
  logic          RESETn = 1'b0;
  logic [KW-1:0] KEY_IN = '0;
  logic          KEY_IN_VALID = 1'b0;
  logic          SEARCH_DONE = 1'b0;
  logic          KEY_CLK = 1'b0;
  logic          KEY_DATA, KEY_VALID, OVERFLOW, DONE;
  logic [2:0]    COUNT;

  crypto1_key_serializer #(.KEY_W(KW), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESETn(RESETn), .KEY_IN(KEY_IN),
    .KEY_IN_VALID(KEY_IN_VALID), .SEARCH_DONE(SEARCH_DONE),
    .KEY_CLK(KEY_CLK), .KEY_DATA(KEY_DATA), .KEY_VALID(KEY_VALID),
    .OVERFLOW(OVERFLOW), .COUNT(COUNT), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int mcount = 0;
  logic [NB-1:0] sb [$];

  typedef struct {
    logic [KW-1:0] key;
    logic          msb;
  } vec_t;
  vec_t tbl [5];

  function automatic logic [NB-1:0] exp_word(input logic [KW-1:0] k);
`ifdef CRYPTO1_KEY_PARITY_EN
    return {k, ~^k};
`else
    return k;
`endif
  endfunction

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, e);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESETn = 1'b0;
    KEY_CLK = 1'b0;
    KEY_IN_VALID = 1'b0;
    step();
    step();
    RESETn = 1'b1;
    sb.delete();
    mcount = 0;
  endtask

  task automatic push(input logic [KW-1:0] k);
    KEY_IN = k;
    KEY_IN_VALID = 1'b1;
    step();
    KEY_IN_VALID = 1'b0;
    if (mcount < DEPTH) begin
      sb.push_back(exp_word(k));
      mcount++;
    end
  endtask

  task automatic recv(input string n, input bit pw,
                      input logic [KW-1:0] pk);
    logic [NB-1:0] w, e;
    w = '0;
    for (int i = 0; i < NB; i++) begin
      KEY_CLK = 1'b1;
      step();
      w = {w[NB-2:0], KEY_DATA};
      chk({n, "_valid_hold"}, KEY_VALID, 1);
      KEY_CLK = 1'b0;
      if (i == NB - 1 && pw) begin
        KEY_IN = pk;
        KEY_IN_VALID = 1'b1;
      end
      step();
      KEY_IN_VALID = 1'b0;
    end
    mcount--;
    if (pw) begin
      sb.push_back(exp_word(pk));
      mcount++;
    end
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s actual=%0h expected=none", n, w);
    end else begin
      e = sb.pop_front();
      chk(n, w, e);
    end
  endtask

  initial begin
    tbl[0] = '{48'hEE3DE5499562, 1'b1};
    tbl[1] = '{48'h27568D75631F, 1'b0};
    tbl[2] = '{48'h000000000001, 1'b0};
    tbl[3] = '{48'hFFFFFFFFFFFF, 1'b1};
    tbl[4] = '{48'h800000000000, 1'b1};

    do_reset();
    chk("rst_data", KEY_DATA, 0);
    chk("rst_valid", KEY_VALID, 0);
    chk("rst_ovf", OVERFLOW, 0);
    chk("rst_count", COUNT, 0);
    chk("rst_done", DONE, 0);

    for (int i = 0; i < 5; i++) begin
      push(tbl[i].key);
      chk("tbl_count1", COUNT, 1);
      chk("tbl_valid", KEY_VALID, 1);
      chk("tbl_msb", KEY_DATA, tbl[i].msb);
      recv("tbl_word", 0, '0);
      chk("tbl_valid_drop", KEY_VALID, 0);
      chk("tbl_count0", COUNT, 0);
      chk("tbl_data_idle", KEY_DATA, 0);
    end

    push(48'h27568D75631F);
    push(48'h5A7BE10A7259);
    chk("b2b_count2", COUNT, 2);
    recv("b2b_w0", 0, '0);
    chk("b2b_count1", COUNT, 1);
    chk("b2b_next_msb", KEY_DATA, 0);
    recv("b2b_w1", 0, '0);
    chk("b2b_count0", COUNT, 0);

    for (int i = 0; i < DEPTH + 1; i++)
      push(48'h100000000000 * (i + 1) + 48'h0000A5A5A5A5);
    chk("ovf_count", COUNT, 4);
    chk("ovf_flag", OVERFLOW, 1);
    for (int i = 0; i < DEPTH; i++)
      recv("ovf_word", 0, '0);
    chk("ovf_sticky", OVERFLOW, 1);
    chk("ovf_empty", COUNT, 0);

    do_reset();
    for (int i = 0; i < DEPTH; i++)
      push(48'hC0FFEE000000 + 48'(i * 7919));
    chk("full_count", COUNT, 4);
    recv("full_w0", 1, 48'h123456789ABC);
    chk("full_count_kept", COUNT, 4);
    chk("full_no_ovf", OVERFLOW, 0);
    for (int i = 0; i < DEPTH; i++)
      recv("full_drain", 0, '0);
    chk("full_drained", COUNT, 0);

    do_reset();
    SEARCH_DONE = 1'b1;
    push(48'h0F0F0F0F0F0F);
    chk("done_busy", DONE, 0);
    recv("done_word", 0, '0);
    chk("done_not_yet", DONE, 0);
    begin
      int n = 0;
      while (DONE !== 1'b1 && n < 4) begin
        step();
        n++;
      end
    end
    chk("done_set", DONE, 1);
    SEARCH_DONE = 1'b0;
    step();
    chk("done_drop", DONE, 0);

    push(48'hEE3DE5499562);
    for (int i = 0; i < 20; i++) begin
      KEY_CLK = 1'b1;
      step();
      KEY_CLK = 1'b0;
      step();
    end
    chk("mid_valid", KEY_VALID, 1);
    RESETn = 1'b0;
    step();
    chk("mrst_data", KEY_DATA, 0);
    chk("mrst_valid", KEY_VALID, 0);
    chk("mrst_ovf", OVERFLOW, 0);
    chk("mrst_count", COUNT, 0);
    chk("mrst_done", DONE, 0);
    RESETn = 1'b1;
    sb.delete();
    mcount = 0;
    step();
    push(48'h5A7BE10A7259);
    recv("post_rst_word", 0, '0);
    chk("post_rst_count", COUNT, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
